vga_pixel_fetch: RTL and testbench

Video-memory read engine between the memory controller's video read port and the VGA display's pixel input. It walks the framebuffer sequentially over the 15-bit word address / 16-bit data port and buffers words in a small FIFO. Each word is unpacked into two 8-bit rrr_ggg_bb pixels, high byte first, and presented over a valid/ready stream with start-of-frame and end-of-line markers. The display stays decoupled from memory latency, and fetching is spread across active time.

---
 rtl/vga_pixel_fetch.sv | 174 +++++++++++++++++
 tb/tb_vga_pixel_fetch.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch: framebuffer read engine feeding the VGA pixel stream.
//
// Walks the framebuffer sequentially (one 16-bit word per read, data back one
// cycle after the address), buffers words in a small FIFO and unpacks each word
// into two 8-bit rrr_ggg_bb pixels, high byte first, on a valid/ready stream.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   enable              fetch enable (low = issue no new reads)
//   frame_sync          one-cycle pulse, restart at frame start
//   vga_addr, vga_data  memory controller video read port
//   pix_valid/ready     pixel stream handshake
//   pix_data            pixel, rrr_ggg_bb
//   pix_sof, pix_eol    start-of-frame / end-of-line markers
//   underrun            sticky: consumer was ready while no pixel was available
//   underrun_count      saturating underrun cycle count
//
// Build option: define PIXFETCH_UNDERRUN_COUNT_EN to include the underrun cycle
// counter; otherwise underrun_count is tied to zero.
//
// state | meaning
// FETCH | issuing sequential reads while the FIFO has room
// DONE  | whole frame requested; idle until frame_sync

module vga_pixel_fetch #(
  parameter int          H_PIXELS   = 320,
  parameter int          V_LINES    = 200,
  parameter logic [14:0] BASE_ADDR  = 15'h0000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        frame_sync,
  output logic [14:0] vga_addr,
  input  logic [15:0] vga_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [7:0]  pix_data,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        underrun,
  output logic [15:0] underrun_count
);

  localparam int WORDS = H_PIXELS * V_LINES / 2;
  localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = PW + 1;
  localparam int XW    = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int YW    = (V_LINES > 1) ? $clog2(V_LINES) : 1;

  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);
  localparam logic [XW-1:0] X_LAST   = XW'(H_PIXELS - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_LINES - 1);
  localparam logic [CW:0]   DEPTH_C  = (CW+1)'(FIFO_DEPTH);

  typedef enum logic {FETCH = 1'b0, DONE = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   word_idx;
  logic            inflight;
  logic [15:0]     fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   fifo_count;
  logic            half;
  logic [XW-1:0]   x_pos;
  logic [YW-1:0]   y_pos;
  logic            underrun_q;

  logic            issue;
  logic            push, pop, xfer;
  logic            fifo_empty;
  logic            has_room;
  logic            underrun_cond;
  logic [15:0]     head;

  // Word index never advances past the last word, so in DONE the address
  // naturally holds the last word issued.
  assign vga_addr   = BASE_ADDR + 15'(word_idx);

  assign fifo_empty = (fifo_count == '0);
  // Counting the in-flight word as occupied reserves its slot before it lands.
  assign has_room   = ({1'b0, fifo_count} + {{CW{1'b0}}, inflight}) < DEPTH_C;

  assign head      = fifo_mem[rd_ptr];
  assign pix_valid = ~fifo_empty;
  assign pix_data  = half ? head[7:0] : head[15:8];
  assign pix_sof   = pix_valid & (x_pos == '0) & (y_pos == '0);
  assign pix_eol   = pix_valid & (x_pos == X_LAST);
  assign underrun  = underrun_q;

  assign xfer = pix_valid & pix_ready & ~frame_sync;
  assign pop  = xfer & half;
  assign push = inflight & ~frame_sync;

  assign underrun_cond = pix_ready & fifo_empty & (state_q != DONE) & ~frame_sync;

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    if (frame_sync) begin
      state_d = FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          issue = enable & has_room;
          if (issue && word_idx == LAST_IDX) state_d = DONE;
        end
        DONE:    state_d = DONE;
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= vga_data;
  end

  always_ff @(posedge clk) begin
    if (reset || frame_sync) begin
      word_idx   <= '0;
      inflight   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      half       <= 1'b0;
      x_pos      <= '0;
      y_pos      <= '0;
      underrun_q <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue && word_idx != LAST_IDX) word_idx <= word_idx + 1'b1;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (pop && !push) fifo_count <= fifo_count - 1'b1;

      if (xfer) begin
        half <= ~half;
        if (x_pos == X_LAST) begin
          x_pos <= '0;
          y_pos <= (y_pos == Y_LAST) ? '0 : y_pos + 1'b1;
        end else begin
          x_pos <= x_pos + 1'b1;
        end
      end

      if (underrun_cond) underrun_q <= 1'b1;
    end
  end

`ifdef PIXFETCH_UNDERRUN_COUNT_EN
  logic [15:0] underrun_cnt_q;

  always_ff @(posedge clk) begin
    if (reset || frame_sync)
      underrun_cnt_q <= '0;
    else if (underrun_cond && underrun_cnt_q != 16'hFFFF)
      underrun_cnt_q <= underrun_cnt_q + 16'd1;
  end

  assign underrun_count = underrun_cnt_q;
`else
  assign underrun_count = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Self-checking bench for vga_pixel_fetch (4x2 frame, 4-word FIFO, base 0x10).
// A queue-based reference model predicts every output each cycle; directed
// scenarios also compare the received pixel stream against the fixed frame.

module tb_vga_pixel_fetch;

  localparam int          H     = 4;
  localparam int          V     = 2;
  localparam int          D     = 4;
  localparam logic [14:0] BASE  = 15'h0010;
  localparam int          WORDS = H * V / 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        frame_sync = 1'b0;
  logic [14:0] vga_addr;
  logic [15:0] vga_data = 16'h0000;
  logic        pix_valid;
  logic        pix_ready = 1'b0;
  logic [7:0]  pix_data;
  logic        pix_sof;
  logic        pix_eol;
  logic        underrun;
  logic [15:0] underrun_count;

  int n_chk = 0;
  int n_err = 0;

  vga_pixel_fetch #(
    .H_PIXELS(H), .V_LINES(V), .BASE_ADDR(BASE), .FIFO_DEPTH(D)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .frame_sync(frame_sync),
    .vga_addr(vga_addr), .vga_data(vga_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_sof(pix_sof), .pix_eol(pix_eol),
    .underrun(underrun), .underrun_count(underrun_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] word_of(input logic [14:0] a);
    return {8'hA0 | {4'h0, a[3:0]}, 8'hB0 | {4'h0, a[3:0]}};
  endfunction

  always @(posedge clk) vga_data <= word_of(vga_addr);

  // reference model state
  logic [15:0] m_q[$];
  int          m_idx;
  bit          m_done;
  bit          m_infl;
  logic [14:0] m_infl_addr;
  bit          m_half;
  int          m_x, m_y;
  bit          m_under;
  int          m_ucnt;

  logic [7:0]  got[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_idx = 0; m_done = 0; m_infl = 0; m_infl_addr = BASE;
    m_half = 0; m_x = 0; m_y = 0; m_under = 0; m_ucnt = 0;
  endfunction

  function automatic void model_step(input bit en, input bit rdy, input bit fs, input bit rst);
    bit xfer;
    bit iss;
    if (rst || fs) begin
      model_reset();
      return;
    end
    xfer = (m_q.size() != 0) && rdy;
    iss  = !m_done && en && ((m_q.size() + int'(m_infl)) < D);
    if (rdy && m_q.size() == 0 && !m_done) begin
      m_under = 1;
      if (m_ucnt < 65535) m_ucnt++;
    end
    if (xfer) begin
      if (m_half) void'(m_q.pop_front());
      m_half = !m_half;
      if (m_x == H - 1) begin
        m_x = 0;
        m_y = (m_y == V - 1) ? 0 : m_y + 1;
      end else begin
        m_x++;
      end
    end
    if (m_infl) m_q.push_back(word_of(m_infl_addr));
    m_infl      = iss;
    m_infl_addr = BASE + 15'(m_idx);
    if (iss) begin
      if (m_idx == WORDS - 1) m_done = 1;
      else m_idx++;
    end
  endfunction

  task automatic check_outputs();
    bit          ev;
    logic [15:0] exp_cnt;
    ev = (m_q.size() != 0);
    check_val("vga_addr", vga_addr, BASE + 15'(m_idx));
    check_val("pix_valid", pix_valid, ev);
    if (ev) check_val("pix_data", pix_data, m_half ? m_q[0][7:0] : m_q[0][15:8]);
    check_val("pix_sof", pix_sof, ev && m_x == 0 && m_y == 0);
    check_val("pix_eol", pix_eol, ev && m_x == H - 1);
    check_val("underrun", underrun, m_under);
`ifdef PIXFETCH_UNDERRUN_COUNT_EN
    exp_cnt = 16'(m_ucnt);
`else
    exp_cnt = 16'h0000;
`endif
    check_val("underrun_count", underrun_count, exp_cnt);
  endtask

  task automatic cycle(input bit en, input bit rdy, input bit fs, input bit rst);
    @(negedge clk);
    check_outputs();
    enable = en; pix_ready = rdy; frame_sync = fs; reset = rst;
    if (pix_valid && rdy && !fs && !rst) got.push_back(pix_data);
    model_step(en, rdy, fs, rst);
  endtask

  task automatic check_frame(input string tag);
    check_val({tag, "_count"}, got.size(), 2 * WORDS);
    for (int w = 0; w < WORDS; w++) begin
      if (2 * w + 1 < got.size()) begin
        check_val({tag, "_hi"}, got[2*w],   8'hA0 | 8'(w));
        check_val({tag, "_lo"}, got[2*w+1], 8'hB0 | 8'(w));
      end
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);

    // straight frame fetch
    cycle(0, 0, 0, 1);
    got.delete();
    repeat (20) cycle(1, 1, 0, 0);
    check_frame("frame_basic");

    // consumer stalled: FIFO fills with the whole frame, then drains in order
    cycle(0, 0, 0, 1);
    got.delete();
    repeat (12) cycle(1, 0, 0, 0);
    @(posedge clk); #1;
    check_val("stall_last_addr", vga_addr, 15'h0013);
    check_val("stall_head", pix_data, 8'hA0);
    repeat (12) cycle(1, 1, 0, 0);
    check_frame("frame_stall");

    // frame_sync while word 0x11 is in flight
    cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 1, 0);
    @(posedge clk); #1;
    check_val("fs_empty", pix_valid, 1'b0);
    check_val("fs_addr", vga_addr, BASE);
    got.delete();
    repeat (20) cycle(1, 1, 0, 0);
    check_frame("frame_after_sync");

    // enable low from reset with consumer ready
    cycle(0, 0, 0, 1);
    repeat (5) cycle(0, 1, 0, 0);
    @(posedge clk); #1;
    check_val("under_set", underrun, 1'b1);
`ifdef PIXFETCH_UNDERRUN_COUNT_EN
    check_val("under_cnt5", underrun_count, 16'd5);
`else
    check_val("under_cnt_tied", underrun_count, 16'd0);
`endif
    cycle(0, 0, 1, 0);
    @(posedge clk); #1;
    check_val("under_clr", underrun, 1'b0);
    check_val("under_cnt_clr", underrun_count, 16'd0);

    // enable toggling every cycle
    cycle(0, 0, 0, 1);
    got.delete();
    for (int i = 0; i < 40; i++) cycle(i[0] == 1'b0, 1, 0, 0);
    check_frame("frame_toggle");

    // reset while a read is in flight
    cycle(0, 0, 0, 1);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 1);
    @(posedge clk); #1;
    check_val("rst_addr", vga_addr, BASE);
    check_val("rst_valid", pix_valid, 1'b0);
    check_val("rst_under", underrun, 1'b0);
    repeat (4) cycle(0, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 63) == 0, $urandom_range(0, 299) == 0);
    cycle(0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
